// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: shared types and decode helpers for the riscv_mdu block.
//   mdu_op_e    : RV32M funct3 encodings
//   mdu_state_e : controller states (IDLE, CALC, DONE)
//   is_signed_a / is_signed_b / is_div : operand signedness and divide decode
package riscv_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/riscv_mdu_iter_step.sv
// mdu_iter_step: one combinational iteration on the 2*XLEN accumulator.
//   Multiply: acc = {partial_hi, multiplier_lo}; adds opnd (multiplicand) to the
//             high half when the current multiplier bit is set, then shifts right.
//   Divide  : acc = {remainder, dividend_bits}; shifts left one bit, subtracts
//             opnd (divisor) when it fits, and shifts the quotient bit in.
// Ports: div (divide select, only with RISCV_MDU_DIV_EN), acc, opnd, acc_next.
// Macro RISCV_MDU_DIV_EN: when undefined the divide step is not built.
module mdu_iter_step #(
    parameter int XLEN = 32
) (
`ifdef RISCV_MDU_DIV_EN
    input  logic                div,
`endif
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] mul_sum;

    always_comb begin
        // Extra carry bit so the add never loses its top bit before the shift.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_next = {mul_sum, acc[XLEN-1:1]};
`ifdef RISCV_MDU_DIV_EN
        if (div) begin
            acc_next = div_step(acc, opnd);
        end
`endif
    end

`ifdef RISCV_MDU_DIV_EN
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] a,
                                                   input logic [XLEN-1:0]   d);
        logic [XLEN:0]   rem_shift;
        logic [XLEN:0]   diff;
        logic            ge;
        logic [XLEN-1:0] new_rem;
        // Remainder is always below the divisor, so the shifted value fits XLEN+1 bits.
        rem_shift = a[2*XLEN-1:XLEN-1];
        ge        = rem_shift >= {1'b0, d};
        diff      = rem_shift - {1'b0, d};
        new_rem   = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        return {new_rem, a[XLEN-2:0], ge};
    endfunction
`endif

endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RV32M multiply/divide unit (shift-add / restoring divide).
//   clk, rst (async, active-high)
//   start, op[2:0] (funct3), A (rs1), B (rs2)  : request, captured on acceptance
//   busy, done, ALUout, illegal                : status and result
// Handshake: a request is accepted on a rising edge where start=1 and busy=0;
// busy stays high from the next cycle through the done cycle, starts seen while
// busy are dropped. done is a one-cycle pulse with ALUout valid; ALUout holds
// until the next accepted request.
// Macro RISCV_MDU_DIV_EN: defined builds all eight ops; undefined builds the
// multiply-only subset where divide ops complete at once with illegal=1.
import riscv_mdu_pkg::*;

module riscv_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] ALUout,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e         state, state_next;
    mdu_op_e            op_in;
    logic [CW-1:0]      cnt;
    logic [2*XLEN-1:0]  acc, acc_next, prod;
    logic [XLEN-1:0]    opnd, mag_a, mag_b, fast_res, res_final;
    logic               neg_a, neg_b, neg_a_in, neg_b_in, mul_lo_q;
    logic               accept, fast, last_step;
`ifdef RISCV_MDU_DIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic               div_q, rem_q;
    logic [XLEN-1:0]    quot, rem, q_fix, r_fix;
`else
    logic               op_ill, ill_q;
`endif

    assign op_in     = mdu_op_e'(op);
    assign accept    = (state == IDLE) && start;
    assign last_step = (cnt == CW'(XLEN - 1));

    mdu_iter_step #(.XLEN(XLEN)) u_step (
`ifdef RISCV_MDU_DIV_EN
        .div      (div_q),
`endif
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    // Operand magnitudes and the fast-path (special case / illegal) decode.
    always_comb begin
        neg_a_in = is_signed_a(op_in) & A[XLEN-1];
        neg_b_in = is_signed_b(op_in) & B[XLEN-1];
        mag_a    = neg_a_in ? -A : A;
        mag_b    = neg_b_in ? -B : B;
        fast     = 1'b0;
        fast_res = '0;
`ifdef RISCV_MDU_DIV_EN
        if (is_div(op_in) && (B == '0)) begin
            fast     = 1'b1;
            fast_res = op[1] ? A : '1;           // op[1] selects REM/REMU
        end else if ((op_in == OP_DIV || op_in == OP_REM) && A == MOST_NEG && B == '1) begin
            fast     = 1'b1;
            fast_res = op[1] ? '0 : A;
        end
`else
        op_ill = is_div(op_in);
        fast   = op_ill;
`endif
    end

    // Sign correction of the last step's accumulator, written on entry to DONE.
    always_comb begin
        prod      = (neg_a ^ neg_b) ? -acc_next : acc_next;
        res_final = mul_lo_q ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef RISCV_MDU_DIV_EN
        quot  = acc_next[XLEN-1:0];
        rem   = acc_next[2*XLEN-1:XLEN];
        q_fix = (neg_a ^ neg_b) ? -quot : quot;
        r_fix = neg_a ? -rem : rem;          // remainder follows the dividend
        if (div_q) begin
            res_final = rem_q ? r_fix : q_fix;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = fast ? DONE : CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            mul_lo_q <= 1'b0;
            ALUout   <= '0;
`ifdef RISCV_MDU_DIV_EN
            div_q    <= 1'b0;
            rem_q    <= 1'b0;
`else
            ill_q    <= 1'b0;
`endif
        end else if (accept) begin
            cnt      <= '0;
            neg_a    <= neg_a_in;
            neg_b    <= neg_b_in;
            mul_lo_q <= (op_in == OP_MUL);
            acc      <= {{XLEN{1'b0}}, mag_b};
            opnd     <= mag_a;
`ifdef RISCV_MDU_DIV_EN
            div_q    <= is_div(op_in);
            rem_q    <= op[1];
            if (is_div(op_in)) begin
                acc  <= {{XLEN{1'b0}}, mag_a};
                opnd <= mag_b;
            end
`else
            ill_q    <= op_ill;
`endif
            if (fast) begin
                ALUout <= fast_res;
            end
        end else if (state == CALC) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                ALUout <= res_final;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
`ifdef RISCV_MDU_DIV_EN
    assign illegal = 1'b0;
`else
    assign illegal = done & ill_q;
`endif

endmodule
